pc_sequencer: RTL

- Single-clock instruction sequencer that controls the PC block.
- Steps each instruction through fetch, decode, execute and PC-update.
- Drives the PC's pc_latch_data and pc_ctl so the PC increments, branches relative by imm, jumps to sr1_val, or holds.
- Also handles halt/resume, execute stalls and a retired-instruction counter. Sits between instruction memory handshake, decode logic and the PC.

---
 rtl/pc_sequencer_if.sv | 38 +++
 rtl/pc_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the pc_sequencer and its surroundings (instruction
// memory handshake, decode flags, execute unit, PC control).
interface pc_sequencer_if #(
    parameter int CNT_BITS = 8
);
    logic                run;
    logic                fetch_ack;
    logic                is_branch;
    logic                br_taken;
    logic                is_jump;
    logic                is_halt;
    logic                exec_busy;
    logic                resume;
    logic                step;
    logic                fetch_req;
    logic                ir_load;
    logic                exec_en;
    logic                pc_latch_data;
    logic [1:0]          pc_ctl;
    logic                halted;
    logic [CNT_BITS-1:0] instr_count;

    // Sequencer side
    modport master (
        input  run, fetch_ack, is_branch, br_taken, is_jump, is_halt,
               exec_busy, resume, step,
        output fetch_req, ir_load, exec_en, pc_latch_data, pc_ctl,
               halted, instr_count
    );

    // Environment side
    modport slave (
        output run, fetch_ack, is_branch, br_taken, is_jump, is_halt,
               exec_busy, resume, step,
        input  fetch_req, ir_load, exec_en, pc_latch_data, pc_ctl,
               halted, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction sequencer: FETCH -> DECODE -> EXEC -> UPDATE, with HALT/resume and a
// retired-instruction counter. Optional PC_SINGLE_STEP_EN gates each instruction on step.
module pc_sequencer #(
    parameter int CNT_BITS = 8
) (
    input  logic           clka,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0]          SEL_INC  = 2'b00;
    localparam logic [1:0]          SEL_REL  = 2'b01;
    localparam logic [1:0]          SEL_JMP  = 2'b10;
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    state_t              state_r;
    state_t              state_s;
    logic [1:0]          sel_r;
    logic [1:0]          sel_s;
    logic [CNT_BITS-1:0] count_r;

    logic       fetch_req_s, ir_load_s, exec_en_s, pc_latch_s, halted_s;
    logic [1:0] pc_ctl_s;
    logic       fetch_req_r, ir_load_r, exec_en_r, pc_latch_r, halted_r;
    logic [1:0] pc_ctl_r;
    logic       go_s;

`ifdef PC_SINGLE_STEP_EN
    assign go_s = bus.run & bus.step;
`else
    logic step_unused_s;
    assign step_unused_s = bus.step;
    assign go_s          = bus.run;
`endif

    // Next-state and PC-select capture
    always_comb begin
        state_s = state_r;
        sel_s   = sel_r;
        case (state_r)
            ST_IDLE: begin
                if (go_s) state_s = ST_FETCH;
                else      state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (bus.fetch_ack) state_s = ST_DECODE;
                else               state_s = ST_FETCH;
            end
            ST_DECODE: begin
                // halt outranks jump, jump outranks a taken branch
                if (bus.is_halt) begin
                    sel_s   = SEL_INC;
                    state_s = ST_HALT;
                end else begin
                    if (bus.is_jump)                      sel_s = SEL_JMP;
                    else if (bus.is_branch && bus.br_taken) sel_s = SEL_REL;
                    else                                  sel_s = SEL_INC;
                    state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.exec_busy) state_s = ST_EXEC;
                else               state_s = ST_UPDATE;
            end
            ST_UPDATE: begin
`ifdef PC_SINGLE_STEP_EN
                state_s = ST_IDLE;
`else
                if (bus.run) state_s = ST_FETCH;
                else         state_s = ST_IDLE;
`endif
            end
            ST_HALT: begin
                // resuming retires the halt itself and steps past it
                if (bus.resume) begin
                    sel_s   = SEL_INC;
                    state_s = ST_UPDATE;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                sel_s   = SEL_INC;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, so the output flops track the state register
    always_comb begin
        fetch_req_s = 1'b0;
        ir_load_s   = 1'b0;
        exec_en_s   = 1'b0;
        pc_latch_s  = 1'b0;
        pc_ctl_s    = SEL_INC;
        halted_s    = 1'b0;
        case (state_s)
            ST_IDLE:   fetch_req_s = 1'b0;
            ST_FETCH:  fetch_req_s = 1'b1;
            ST_DECODE: ir_load_s   = 1'b1;
            ST_EXEC:   exec_en_s   = 1'b1;
            ST_UPDATE: begin
                pc_latch_s = 1'b1;
                pc_ctl_s   = sel_s;
            end
            ST_HALT:   halted_s    = 1'b1;
            default:   halted_s    = 1'b0;
        endcase
    end

    // State, select and output registers
    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            sel_r       <= SEL_INC;
            fetch_req_r <= 1'b0;
            ir_load_r   <= 1'b0;
            exec_en_r   <= 1'b0;
            pc_latch_r  <= 1'b0;
            pc_ctl_r    <= SEL_INC;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            sel_r       <= sel_s;
            fetch_req_r <= fetch_req_s;
            ir_load_r   <= ir_load_s;
            exec_en_r   <= exec_en_s;
            pc_latch_r  <= pc_latch_s;
            pc_ctl_r    <= pc_ctl_s;
            halted_r    <= halted_s;
        end
    end

    // Retired-instruction counter, bumped as each UPDATE cycle completes
    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
        end else if (state_r == ST_UPDATE) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign bus.fetch_req     = fetch_req_r;
    assign bus.ir_load       = ir_load_r;
    assign bus.exec_en       = exec_en_r;
    assign bus.pc_latch_data = pc_latch_r;
    assign bus.pc_ctl        = pc_ctl_r;
    assign bus.halted        = halted_r;
    assign bus.instr_count   = count_r;

endmodule
